// File: rtl/spi_regfile_rx.sv
// spi_regfile_rx
//   Write-only SPI (mode 0) receiver feeding five 8-bit configuration
//   registers. A frame is 16 bits, MSB first: bit15 = R/W (1 = write),
//   bits 14:8 = address, bits 7:0 = data. Only writes to addresses
//   0x00..0x04 with exactly 16 SCLK rises are committed.
//
// Ports
//   clk              sole clock, rising edge
//   rst              synchronous active-high reset
//   ui_in[0]         SCLK (async)
//   ui_in[1]         COPI (async)
//   ui_in[2]         nCS  (async, active low)
//   ui_in[7:3]       unused
//   en_reg_out_7_0   register 0x00
//   en_reg_out_15_8  register 0x01
//   en_reg_pwm_7_0   register 0x02
//   en_reg_pwm_15_8  register 0x03
//   pwm_duty_cycle   register 0x04
//   frame_ok         one-cycle pulse, write committed
//   frame_err        one-cycle pulse, frame discarded
module spi_regfile_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ui_in,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       frame_ok,
  output logic       frame_err
);

  typedef enum logic {IDLE, RECV} state_t;

  logic unused_bits;
  assign unused_bits = &{1'b0, ui_in[7:3]};

  // Input synchronizers. nCS resets to its inactive (high) level.
  logic [SYNC_STAGES-1:0] sclk_sync, copi_sync, ncs_sync;

  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge value of its neighbours; = here would collapse the chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      copi_sync <= '0;
      ncs_sync  <= '1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], ui_in[0]};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], ui_in[1]};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ui_in[2]};
    end
  end

  logic sclk_s, copi_s, ncs_s;
  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign copi_s = copi_sync[SYNC_STAGES-1];
  assign ncs_s  = ncs_sync[SYNC_STAGES-1];

  // Edge detection against one-cycle-delayed copies; the detected edges are
  // registered, and COPI is delayed alongside so it lines up with sclk_rise_q.
  logic sclk_d, copi_d, ncs_d;
  logic sclk_rise_q, ncs_fall_q, ncs_rise_q;

  // After reset the nCS chain still holds its forced-high value for
  // SYNC_STAGES cycles. flush marks when the chain reflects the real pin;
  // armed is set once a genuine high nCS has been seen, so a frame already
  // in progress at reset release cannot fake an nCS fall.
  logic [SYNC_STAGES-1:0] flush;
  logic                   armed;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_d      <= 1'b0;
      copi_d      <= 1'b0;
      ncs_d       <= 1'b1;
      flush       <= '0;
      armed       <= 1'b0;
      sclk_rise_q <= 1'b0;
      ncs_fall_q  <= 1'b0;
      ncs_rise_q  <= 1'b0;
    end else begin
      sclk_d      <= sclk_s;
      copi_d      <= copi_s;
      ncs_d       <= ncs_s;
      flush       <= {flush[SYNC_STAGES-2:0], 1'b1};
      armed       <= armed | ((&flush) & ncs_s);
      sclk_rise_q <= sclk_s & ~sclk_d;
      ncs_fall_q  <= armed & ncs_d & ~ncs_s;
      ncs_rise_q  <= ~ncs_d & ncs_s;
    end
  end

  state_t      state;
  logic [15:0] shift;
  logic [4:0]  bit_cnt;
  logic        frame_valid;

  assign frame_valid = (bit_cnt == 5'd16) && shift[15] && (shift[14:8] <= 7'h04);

  // NOTE: every register, including the datapath shift register and counter,
  // is reset so simulation never carries X into the frame checks.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      shift           <= '0;
      bit_cnt         <= '0;
      en_reg_out_7_0  <= '0;
      en_reg_out_15_8 <= '0;
      en_reg_pwm_7_0  <= '0;
      en_reg_pwm_15_8 <= '0;
      pwm_duty_cycle  <= '0;
      frame_ok        <= 1'b0;
      frame_err       <= 1'b0;
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (ncs_fall_q) begin
            state   <= RECV;
            shift   <= '0;
            bit_cnt <= '0;
          end
        end
        RECV: begin
          // nCS rise wins over a coincident SCLK rise: that bit is dropped.
          if (ncs_rise_q) begin
            state <= IDLE;
            if (frame_valid) begin
              frame_ok <= 1'b1;
              case (shift[14:8])
                7'h00:   en_reg_out_7_0  <= shift[7:0];
                7'h01:   en_reg_out_15_8 <= shift[7:0];
                7'h02:   en_reg_pwm_7_0  <= shift[7:0];
                7'h03:   en_reg_pwm_15_8 <= shift[7:0];
                7'h04:   pwm_duty_cycle  <= shift[7:0];
                default: ;
              endcase
            end else begin
              frame_err <= 1'b1;
            end
          end else if (sclk_rise_q) begin
            shift <= {shift[14:0], copi_d};
            if (bit_cnt != 5'd17) bit_cnt <= bit_cnt + 5'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_regfile_rx.sv
// Testbench for spi_regfile_rx: table of directed SPI frames with expected
// register images and pulse outcomes, plus hand-written sequences for
// commit latency, idle SCLK activity, mid-frame reset and back-to-back frames.
module tb_spi_regfile_rx;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ui_in;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic       frame_ok, frame_err;

  spi_regfile_rx #(.SYNC_STAGES(S)) dut (
    .clk             (clk),
    .rst             (rst),
    .ui_in           (ui_in),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .frame_ok        (frame_ok),
    .frame_err       (frame_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int ok_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  // Pulse accounting, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      ok_cnt  <= ok_cnt + int'(frame_ok);
      err_cnt <= err_cnt + int'(frame_err);
      if (frame_ok && frame_err) both_cnt <= both_cnt + 1;
    end
  end

  function automatic logic [39:0] regs();
    return {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic ncs_low(input int half);
    @(negedge clk);
    ui_in[2] = 1'b0;
    repeat (half) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [16:0] frame, input int nbits, input int half);
    for (int i = nbits - 1; i >= 0; i--) begin
      ui_in[1] = frame[i];
      repeat (half) @(negedge clk);
      ui_in[0] = 1'b1;
      repeat (half) @(negedge clk);
      ui_in[0] = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [16:0] frame, input int nbits, input int half);
    ncs_low(half);
    spi_bits(frame, nbits, half);
    repeat (half) @(negedge clk);
    ui_in[2] = 1'b1;
    repeat (S + 8) @(negedge clk);
  endtask

  typedef struct {
    string       name;
    logic [16:0] frame;
    int          nbits;
    int          exp_ok;
    int          exp_err;
    logic [39:0] exp_regs;  // {pwm_duty, pwm_15_8, pwm_7_0, out_15_8, out_7_0}
  } vec_t;

  vec_t vecs[11];

  initial begin
    int ok0, err0;
    logic [39:0] r0;

    vecs[0]  = '{"w_8455",   17'h08455, 16, 1, 0, 40'h55_00_00_00_00};
    vecs[1]  = '{"w_80F0",   17'h080F0, 16, 1, 0, 40'h55_00_00_00_F0};
    vecs[2]  = '{"w_810F",   17'h0810F, 16, 1, 0, 40'h55_00_00_0F_F0};
    vecs[3]  = '{"w_82AA",   17'h082AA, 16, 1, 0, 40'h55_00_AA_0F_F0};
    vecs[4]  = '{"w_8355",   17'h08355, 16, 1, 0, 40'h55_55_AA_0F_F0};
    vecs[5]  = '{"rd_0412",  17'h00412, 16, 0, 1, 40'h55_55_AA_0F_F0};
    vecs[6]  = '{"addr05",   17'h085FF, 16, 0, 1, 40'h55_55_AA_0F_F0};
    vecs[7]  = '{"addr7F",   17'h0FF12, 16, 0, 1, 40'h55_55_AA_0F_F0};
    vecs[8]  = '{"bits15",   17'h04233, 15, 0, 1, 40'h55_55_AA_0F_F0};
    vecs[9]  = '{"bits17",   17'h184AB, 17, 0, 1, 40'h55_55_AA_0F_F0};
    vecs[10] = '{"bits0",    17'h00000,  0, 0, 1, 40'h55_55_AA_0F_F0};

    rst   = 1'b1;
    ui_in = 8'h04;
    repeat (4) @(negedge clk);
    check("rst_regs", regs(), 40'h0);
    check("rst_ok", frame_ok, 0);
    check("rst_err", frame_err, 0);
    rst = 1'b0;
    repeat (S + 6) @(negedge clk);

    for (int v = 0; v < 11; v++) begin
      ok0 = ok_cnt;
      err0 = err_cnt;
      send_frame(vecs[v].frame, vecs[v].nbits, 2);
      check({vecs[v].name, "_ok"},   ok_cnt - ok0,   vecs[v].exp_ok);
      check({vecs[v].name, "_err"},  err_cnt - err0, vecs[v].exp_err);
      check({vecs[v].name, "_regs"}, regs(),         vecs[v].exp_regs);
    end

    // Commit latency: pulse and register update land S+2 edges after nCS
    // is first sampled high, and the pulse lasts one cycle.
    ncs_low(2);
    spi_bits(17'h08011, 16, 2);
    repeat (2) @(negedge clk);
    ui_in[2] = 1'b1;
    for (int k = 1; k <= S + 3; k++) begin
      @(negedge clk);
      check($sformatf("lat_ok_%0d", k), frame_ok, (k == S + 2) ? 1 : 0);
      check($sformatf("lat_reg_%0d", k), en_reg_out_7_0, (k >= S + 2) ? 8'h11 : 8'hF0);
    end
    repeat (S + 4) @(negedge clk);

    // SCLK/COPI activity while nCS is high does nothing.
    ok0 = ok_cnt;
    err0 = err_cnt;
    r0 = regs();
    spi_bits(17'h1A5A5, 17, 2);
    repeat (S + 8) @(negedge clk);
    check("idle_ok", ok_cnt - ok0, 0);
    check("idle_err", err_cnt - err0, 0);
    check("idle_regs", regs(), r0);

    // Reset in the middle of a frame; the tail of that frame is ignored.
    ncs_low(2);
    spi_bits(17'h00084, 8, 2);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_regs_in_rst", regs(), 40'h0);
    rst = 1'b0;
    ok0 = ok_cnt;
    err0 = err_cnt;
    spi_bits(17'h000CC, 8, 2);
    repeat (2) @(negedge clk);
    ui_in[2] = 1'b1;
    repeat (S + 8) @(negedge clk);
    check("midrst_regs", regs(), 40'h0);
    check("midrst_ok", ok_cnt - ok0, 0);
    check("midrst_err", err_cnt - err0, 0);
    ok0 = ok_cnt;
    send_frame(17'h084CC, 16, 2);
    check("after_rst_regs", regs(), 40'hCC_00_00_00_00);
    check("after_rst_ok", ok_cnt - ok0, 1);

    // Back-to-back frames at SCLK = clk/8, nCS high for one clock.
    ok0 = ok_cnt;
    err0 = err_cnt;
    ncs_low(4);
    spi_bits(17'h08001, 16, 4);
    repeat (4) @(negedge clk);
    ui_in[2] = 1'b1;
    @(negedge clk);
    ui_in[2] = 1'b0;
    repeat (4) @(negedge clk);
    spi_bits(17'h08002, 16, 4);
    repeat (4) @(negedge clk);
    ui_in[2] = 1'b1;
    repeat (S + 8) @(negedge clk);
    check("b2b_reg0", en_reg_out_7_0, 8'h02);
    check("b2b_ok", ok_cnt - ok0, 2);
    check("b2b_err", err_cnt - err0, 0);

    check("ok_err_overlap", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_regfile_rx.md
SPI_REGFILE_RX -- requirements
Module: spi_regfile_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, flip-flop count of each input synchronizer (legal 2..3).
REQ-002 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port ui_in  input  8  bit0 = SCLK, bit1 = COPI, bit2 = nCS, all asynchronous to clk; bits 7:3 unused.
REQ-005 SHALL have port en_reg_out_7_0  output  8  register 0x00, output enables, pins 7:0.
REQ-006 SHALL have port en_reg_out_15_8  output  8  register 0x01, output enables, pins 15:8.
REQ-007 SHALL have port en_reg_pwm_7_0  output  8  register 0x02, PWM enables, pins 7:0.
REQ-008 SHALL have port en_reg_pwm_15_8  output  8  register 0x03, PWM enables, pins 15:8.
REQ-009 SHALL have port pwm_duty_cycle  output  8  register 0x04, shared PWM duty.
REQ-010 SHALL have port frame_ok  output  1  one-cycle pulse: a write committed.
REQ-011 SHALL have port frame_err  output  1  one-cycle pulse: frame discarded.

Function
REQ-012 SHALL pass SCLK, COPI, nCS each through a SYNC_STAGES-deep synchronizer; all logic uses synchronized copies only.
REQ-013 SHALL detect SCLK rise, nCS fall and nCS rise by comparing the synchronizer output with a one-cycle-delayed copy.
REQ-014 SHALL implement FSM states IDLE and RECV; reset state IDLE.
REQ-015 IDLE -> RECV on nCS fall: clear the 16-bit shift register and the 5-bit bit counter.
REQ-016 In RECV, on each SCLK rise, SHALL shift synchronized COPI into the LSB, MSB first (SPI mode 0), and increment the bit counter, saturating at 17.
REQ-017 RECV -> IDLE on nCS rise, evaluating the frame in the same cycle; SCLK rises coincident with or after nCS rise SHALL be ignored.
REQ-018 Frame format: bit15 = R/W (1 = write), bits 14:8 = address, bits 7:0 = data.
REQ-019 Frame valid iff counter == 16, bit15 == 1, and address <= 0x04.
REQ-020 On a valid frame, SHALL load the addressed output register with the data and pulse frame_ok; no other register changes.
REQ-021 On any other frame (count != 16, read bit, address 0x05..0x7F), SHALL leave all registers unchanged and pulse frame_err.
REQ-022 Registers and pulses SHALL update on the clk edge following the cycle in which nCS rise is detected (SYNC_STAGES+2 clk edges after the first edge sampling nCS high).
REQ-023 frame_ok and frame_err SHALL never be high in the same cycle and SHALL be high for exactly one cycle per frame.
REQ-024 SCLK activity while in IDLE SHALL have no effect.
REQ-025 An nCS pulse with zero SCLK edges SHALL yield frame_err.
REQ-026 Back-to-back frames separated by one synchronized nCS-high cycle SHALL both be processed.

Reset
REQ-027 With rst high at a clk edge, all five registers, frame_ok and frame_err SHALL be 0 and the FSM SHALL be IDLE.
REQ-028 During reset, nCS synchronizer stages SHALL be set to 1 and SCLK/COPI stages to 0.
REQ-029 Reset asserted mid-frame SHALL abandon the frame; RECV is re-entered only on a subsequent nCS fall, so a frame already in progress at reset release is ignored silently.

Verification
REQ-030 Reset, then write frame 0x8455 -> pwm_duty_cycle = 0x55, frame_ok pulses once, other registers remain 0x00.
REQ-031 Write frames 0x80F0, 0x810F, 0x82AA, 0x8355 -> registers 0x00..0x03 = F0, 0F, AA, 55, four frame_ok pulses.
REQ-032 Frame 0x0412 (read) and frame 0x85FF (address 0x05) -> no register change, two frame_err pulses.
REQ-033 15-bit and 17-bit frames carrying 0x84xx -> pwm_duty_cycle unchanged, frame_err each.
REQ-034 Assert rst after 8 SCLK edges of 0x84CC, release with nCS still low, complete the frame -> all registers 0x00, no pulse; next full 0x84CC frame -> pwm_duty_cycle = 0xCC.
REQ-035 SCLK at clk/8, two frames 0x8001 and 0x8002 separated by minimal nCS-high time -> en_reg_out_7_0 = 0x02, two frame_ok pulses.
